// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register: command codes and step-controller states.
// SHREG_ROTATE_EN enables the rotate commands; without it they behave as reserved codes.
package shreg_pkg;

   typedef enum logic [2:0] {
      HOLD  = 3'b000,
      LOAD  = 3'b001,
      SHR   = 3'b010,
      SHL   = 3'b011,
      ROTR  = 3'b100,
      ROTL  = 3'b101,
      CLEAR = 3'b110,
      RSVD  = 3'b111
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // True for commands that consume a step count.
   function automatic logic is_shift(input mode_e m);
      case (m)
         SHR, SHL: return 1'b1;
`ifdef SHREG_ROTATE_EN
         ROTR, ROTL: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/shreg_step_ctrl.sv
// Command FSM and step down-counter; issues one shift strobe per shift edge.
// state | meaning
// IDLE  | waiting for start
// RUN   | remaining shifts pending, one per edge
// DONE  | one-cycle completion pulse; may accept the next command
module shreg_step_ctrl
   import shreg_pkg::*;
#(
   parameter int SW = 3
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          start,
   input  mode_e         mode,
   input  logic [SW-1:0] steps,
   output logic          busy,
   output logic          done,
   output logic          shift_en,
   output logic          accept,
   output mode_e         op
);

   localparam logic [SW-1:0] ONE = SW'(1);

   state_e        state, state_next;
   logic [SW-1:0] cnt, cnt_next;
   mode_e         mode_r, mode_next;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         mode_r <= HOLD;
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         mode_r <= mode_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      mode_next  = mode_r;
      shift_en   = 1'b0;
      accept     = 1'b0;
      op         = mode_r;
      case (state)
         RUN: begin
            shift_en = 1'b1;
            cnt_next = cnt - ONE;
            if (cnt == ONE) state_next = DONE;
         end
         default: begin
            state_next = IDLE;
            if (start && reset_n) begin
               accept    = 1'b1;
               op        = mode;
               mode_next = mode;
               // The first shift lands on the accepting edge itself.
               if (is_shift(mode) && steps != '0) begin
                  shift_en   = 1'b1;
                  cnt_next   = steps - ONE;
                  state_next = (steps == ONE) ? DONE : RUN;
               end else begin
                  state_next = DONE;
               end
            end
         end
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: rtl/shift_register_universal.sv
// Universal WIDTH-bit shift register: load, clear, shift left/right, optional rotate.
// Rotate support is built only when SHREG_ROTATE_EN is defined.
module shift_register_universal
   import shreg_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int SW    = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [SW-1:0]    steps,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ser_in_msb,
   input  logic             ser_in_lsb,
   output logic [WIDTH-1:0] q,
   output logic             ser_out_lsb,
   output logic             ser_out_msb,
   output logic             busy,
   output logic             done
);

   logic             shift_en;
   logic             accept;
   mode_e            op;
   logic [WIDTH-1:0] q_next;

   shreg_step_ctrl #(.SW(SW)) u_ctrl (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .mode     (mode_e'(mode)),
      .steps    (steps),
      .busy     (busy),
      .done     (done),
      .shift_en (shift_en),
      .accept   (accept),
      .op       (op)
   );

   always_comb begin
      q_next = q;
      if (shift_en) begin
         case (op)
            SHR:     q_next = {ser_in_msb, q[WIDTH-1:1]};
            SHL:     q_next = {q[WIDTH-2:0], ser_in_lsb};
`ifdef SHREG_ROTATE_EN
            ROTR:    q_next = {q[0], q[WIDTH-1:1]};
            ROTL:    q_next = {q[WIDTH-2:0], q[WIDTH-1]};
`endif
            default: q_next = q;
         endcase
      end else if (accept) begin
         case (op)
            LOAD:    q_next = load_data;
            CLEAR:   q_next = '0;
            default: q_next = q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) q <= '0;
      else          q <= q_next;
   end

   assign ser_out_lsb = q[0];
   assign ser_out_msb = q[WIDTH-1];

endmodule

// File: tb/tb_shift_register_universal.sv
// Scoreboard bench for shift_register_universal (WIDTH=4): commands push the expected
// final q; a monitor pops and compares on every done pulse.
module tb_shift_register_universal;

   localparam logic [2:0] M_HOLD = 3'b000, M_LOAD = 3'b001, M_SHR = 3'b010, M_SHL = 3'b011;
   localparam logic [2:0] M_ROTR = 3'b100, M_ROTL = 3'b101, M_CLEAR = 3'b110, M_RSVD = 3'b111;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] mode = 3'b000;
   logic [2:0] steps = 3'd0;
   logic [3:0] load_data = 4'h0;
   logic       ser_in_msb = 1'b0;
   logic       ser_in_lsb = 1'b0;
   logic [3:0] q;
   logic       ser_out_lsb, ser_out_msb, busy, done;

   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] exp_queue[$];

   shift_register_universal #(.WIDTH(4)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .mode        (mode),
      .steps       (steps),
      .load_data   (load_data),
      .ser_in_msb  (ser_in_msb),
      .ser_in_lsb  (ser_in_lsb),
      .q           (q),
      .ser_out_lsb (ser_out_lsb),
      .ser_out_msb (ser_out_msb),
      .busy        (busy),
      .done        (done)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse retires one expected result.
   always @(negedge clock) begin
      if (done) begin
         if (exp_queue.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
         end else begin
            logic [3:0] e;
            e = exp_queue.pop_front();
            check("q_at_done", 32'(q), 32'(e));
            check("ser_out_lsb", 32'(ser_out_lsb), 32'(e[0]));
            check("ser_out_msb", 32'(ser_out_msb), 32'(e[3]));
            check("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   // Issue one command from a negedge; returns at the negedge where done is seen.
   task automatic run_cmd(input string name, input logic [2:0] m, input logic [2:0] st,
                          input logic [3:0] data, input logic [7:0] msb_seq,
                          input logic [7:0] lsb_seq, input logic [3:0] exp_q,
                          input int exp_busy, input int exp_lat, input int inject);
      int lat  = 0;
      int bcnt = 0;
      bit got  = 1'b0;
      exp_queue.push_back(exp_q);
      mode       = m;
      steps      = st;
      load_data  = data;
      ser_in_msb = msb_seq[0];
      ser_in_lsb = lsb_seq[0];
      start      = 1'b1;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(negedge clock);
         start      = 1'b0;
         ser_in_msb = msb_seq[i[2:0]];
         ser_in_lsb = lsb_seq[i[2:0]];
         if (i == inject) begin
            start     = 1'b1;
            mode      = M_LOAD;
            load_data = 4'hF;
         end
         lat = i;
         if (busy) bcnt++;
         if (done) got = 1'b1;
      end
      start = 1'b0;
      if (!got) begin
         check({name, "_timeout"}, 32'(got), 32'd1);
         exp_queue.delete();
      end else begin
         check({name, "_latency"}, 32'(lat), 32'(exp_lat));
         check({name, "_busy_cycles"}, 32'(bcnt), 32'(exp_busy));
      end
   endtask

   initial begin
      repeat (2) @(negedge clock);
      check("reset_q", 32'(q), 32'h0);
      check("reset_busy_done", 32'({busy, done}), 32'h0);
      reset_n = 1'b1;

      run_cmd("load_1010", M_LOAD, 3'd0, 4'b1010, 8'h00, 8'h00, 4'b1010, 0, 1, 0);
      reset_n = 1'b0;
      start = 1'b1; mode = M_LOAD; load_data = 4'hF;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         check("rst_q", 32'(q), 32'h0);
         check("rst_busy_done", 32'({busy, done}), 32'h0);
      end
      start = 1'b0;
      reset_n = 1'b1;
      @(negedge clock);

      run_cmd("load_1011", M_LOAD, 3'd0, 4'b1011, 8'h00, 8'h00, 4'b1011, 0, 1, 0);
      run_cmd("clear", M_CLEAR, 3'd0, 4'hF, 8'h00, 8'h00, 4'b0000, 0, 1, 0);
      run_cmd("shr3", M_SHR, 3'd3, 4'h0, 8'b0000_0101, 8'h00, 4'b1010, 2, 3, 0);

      run_cmd("load_1001", M_LOAD, 3'd0, 4'b1001, 8'h00, 8'h00, 4'b1001, 0, 1, 0);
`ifdef SHREG_ROTATE_EN
      run_cmd("rotl5", M_ROTL, 3'd5, 4'h0, 8'h00, 8'h00, 4'b0011, 4, 5, 0);
`else
      run_cmd("rotl5_rsvd", M_ROTL, 3'd5, 4'h0, 8'h00, 8'h00, 4'b1001, 0, 1, 0);
`endif

      run_cmd("load_0110", M_LOAD, 3'd0, 4'b0110, 8'h00, 8'h00, 4'b0110, 0, 1, 0);
      run_cmd("shl0", M_SHL, 3'd0, 4'hF, 8'hFF, 8'hFF, 4'b0110, 0, 1, 0);
      run_cmd("shl2", M_SHL, 3'd2, 4'h0, 8'h00, 8'b0000_0011, 4'b1011, 1, 2, 0);

      run_cmd("load_0110b", M_LOAD, 3'd0, 4'b0110, 8'h00, 8'h00, 4'b0110, 0, 1, 0);
      run_cmd("shr4_inject", M_SHR, 3'd4, 4'h0, 8'b0000_1011, 8'h00, 4'b1011, 3, 4, 1);
      run_cmd("hold", M_HOLD, 3'd3, 4'h0, 8'h00, 8'h00, 4'b1011, 0, 1, 0);
      run_cmd("rsvd", M_RSVD, 3'd3, 4'h0, 8'h00, 8'h00, 4'b1011, 0, 1, 0);

      run_cmd("load_1100", M_LOAD, 3'd0, 4'b1100, 8'h00, 8'h00, 4'b1100, 0, 1, 0);
`ifdef SHREG_ROTATE_EN
      run_cmd("rotr2", M_ROTR, 3'd2, 4'h0, 8'h00, 8'h00, 4'b0011, 1, 2, 0);
`else
      run_cmd("rotr2_rsvd", M_ROTR, 3'd2, 4'h0, 8'h00, 8'h00, 4'b1100, 0, 1, 0);
`endif
      run_cmd("shr7", M_SHR, 3'd7, 4'h0, 8'h00, 8'hFF, 4'b0000, 6, 7, 0);

      // Reset on the second shift edge aborts the command without a done pulse.
      run_cmd("load_0110c", M_LOAD, 3'd0, 4'b0110, 8'h00, 8'h00, 4'b0110, 0, 1, 0);
      mode = M_SHR; steps = 3'd4; ser_in_msb = 1'b1; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("abort_first_shift", 32'(q), 32'b1011);
      check("abort_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      @(negedge clock);
      check("abort_q", 32'(q), 32'h0);
      check("abort_busy_done", 32'({busy, done}), 32'h0);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("abort_quiet", 32'({busy, done}), 32'h0);
      end

      check("scoreboard_empty", 32'(exp_queue.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_register_universal.md
# shift_register_universal

Parametrised universal shift register; successor to the 4-bit serial-in right-shift register, generalised to WIDTH bits. Supports parallel load, clear, left/right shift, and optional rotate. Multi-step shifts run under a small command FSM with busy/done handshake. Sits between serial links and parallel datapaths: serialiser, deserialiser and barrel-style step shifter.

## Interface
- WIDTH, 4: register width in bits, ≥2.
- SW, $clog2(WIDTH)+1: width of the step-count field (derived; not overridden).
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- start  in  1  command strobe; sampled when not busy.
- mode  in  3  command: 000 HOLD, 001 LOAD, 010 SHR, 011 SHL, 100 ROTR, 101 ROTL, 110 CLEAR, 111 reserved.
- steps  in  SW  shift count for modes 010–101; ignored for other modes.
- load_data  in  WIDTH  parallel load value.
- ser_in_msb  in  1  bit inserted at q[WIDTH-1] on SHR.
- ser_in_lsb  in  1  bit inserted at q[0] on SHL.
- q  out  WIDTH  register contents.
- ser_out_lsb  out  1  equals q[0].
- ser_out_msb  out  1  equals q[WIDTH-1].
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states and outputs:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- Command acceptance:
  - A command is accepted on any edge with reset_n=1, start=1 and state≠RUN.
  - mode and steps are captured on the accepting edge.
- SHR: q <= {ser_in_msb, q[WIDTH-1:1]}.
- SHL: q <= {q[WIDTH-2:0], ser_in_lsb}.
- ROTR: q <= {q[0], q[WIDTH-1:1]}.
- ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- Serial inputs are sampled live on every shift edge; they are not captured at acceptance.
- LOAD, CLEAR, HOLD, reserved:
  - q is updated on the accepting edge (load_data / 0 / unchanged / unchanged).
  - Next state is DONE.
- Shift modes, steps=N≥1:
  - The first shift happens on the accepting edge and the counter is loaded with N-1.
  - If N-1=0, next state is DONE; otherwise RUN.
- Shift modes, steps=0: q unchanged, next state is DONE.
- RUN: one shift per edge, counter decrements; the edge where the counter goes 1→0 moves the FSM to DONE.
- steps>WIDTH is legal:
  - Shifts run to completion; after WIDTH shifts q holds only serial-input bits.
  - Rotates wrap modulo WIDTH.
- DONE→IDLE on the next edge unless a new command is accepted. Back-to-back commands are therefore allowed and done still pulses once per command.
- start during RUN is ignored; there is no queueing.
- mode/steps/load_data changes during RUN have no effect.

## Timing
- Reset: reset_n=0 at an edge forces q=0, state IDLE, counter 0, busy=0, done=0. Reset overrides start.
- Reset mid-RUN aborts the command, clears q, and no done pulse is produced.
- Single-cycle commands: q valid after the accepting edge; done is high in the following cycle only.
- N-step shift:
  - Shift k happens on accept edge + (k-1).
  - busy is high for N-1 cycles.
  - done is high for the one cycle after the final shift.
  - Accept-to-done latency is N cycles (1 cycle for N=0 and single-cycle commands).
- ser_out_lsb and ser_out_msb are combinational from q, with no extra latency.

## Configuration
- SHREG_ROTATE_EN defined: ROTR/ROTL behave as above.
- SHREG_ROTATE_EN undefined:
  - Modes 100/101 are treated as reserved: q unchanged, done pulses one cycle later, busy stays 0.
  - No rotate muxing is synthesised.

## Structure
- Package shreg_pkg holds:
  - the mode enum (HOLD, LOAD, SHR, SHL, ROTR, ROTL, CLEAR, RSVD) as 3-bit codes;
  - the FSM state enum (IDLE, RUN, DONE).
- Sub-module shreg_step_ctrl: FSM plus down-counter. Its outputs are busy, done and a shift-enable strobe.
- The top level holds the q register and the next-value mux.

## Test plan
All scenarios use WIDTH=4.
- Reset with q=1010, reset_n=0 for 2 edges with start=1 → q=0000, busy=0, done=0 throughout.
- LOAD load_data=1011 → q=1011 after accept edge; done high exactly one cycle; busy never high.
- SHR from q=0000, steps=3, ser_in_msb=1,0,1 on successive edges → q=1000, 0100, 1010; busy high 2 cycles; done one cycle after the third shift.
- ROTL from q=1001, steps=5 (macro defined) → final q=0011; done 5 cycles after accept.
- Two cases with q=0110:
  - SHL steps=0 → q stays 0110 and done pulses next cycle.
  - SHR steps=4 started, then start+LOAD pulsed during RUN → LOAD ignored; q ends as the 4 serial-input bits.
- Two cases:
  - reset_n=0 on the second shift edge of SHR steps=4 → q=0000, IDLE, no done.
  - Macro undefined, mode=100 on q=1100 → q stays 1100 and done pulses.
